// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg
// Shared types and constants for the framebuffer rectangle-fill engine:
// default screen geometry, coordinate/address types, fill FSM states,
// Avalon register offsets and CTRL bit positions.
// ----------------------------------------------------------------------------
package fb_pkg;

   localparam int H_PIXELS_DEF = 640;
   localparam int V_PIXELS_DEF = 480;
   localparam int FB_ADDR_W    = 19;
   localparam int FB_DATA_W    = 8;

   typedef logic [9:0]           coord_t;
   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} fill_state_e;

   localparam logic [3:0] REG_X0_HI = 4'd0;
   localparam logic [3:0] REG_X0_LO = 4'd1;
   localparam logic [3:0] REG_Y0_HI = 4'd2;
   localparam logic [3:0] REG_Y0_LO = 4'd3;
   localparam logic [3:0] REG_X1_HI = 4'd4;
   localparam logic [3:0] REG_X1_LO = 4'd5;
   localparam logic [3:0] REG_Y1_HI = 4'd6;
   localparam logic [3:0] REG_Y1_LO = 4'd7;
   localparam logic [3:0] REG_COLOR = 4'd8;
   localparam logic [3:0] REG_CTRL  = 4'd9;

   localparam int CTRL_GO      = 0;
   localparam int CTRL_IRQ_CLR = 1;

   // Hi byte only carries coordinate bits [9:8]; lo byte carries [7:0].
   function automatic coord_t coord_merge(input coord_t cur, input logic hi,
                                          input logic [7:0] d);
      return hi ? {d[1:0], cur[7:0]} : {cur[9:8], d};
   endfunction

endpackage

// File: rtl/fb_addr_walker.sv
// ----------------------------------------------------------------------------
// fb_addr_walker
// Walks a rectangle in column-major order and produces the framebuffer
// address of the current pixel (addr = x*V_PIXELS + y). The column base is
// multiplied once on start and then stepped by V_PIXELS per column.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   start            load x0/y0 and compute the first column base
//   advance          current pixel accepted; step to the next one
//   x0,y0,x1,y1      inclusive rectangle bounds (held stable during a walk)
//   addr             address of the current pixel
//   last             current pixel is the final one of the rectangle
// ----------------------------------------------------------------------------
module fb_addr_walker
   import fb_pkg::*;
#(
   parameter int V_PIXELS = V_PIXELS_DEF,
   parameter int ADDR_W   = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              advance,
   input  coord_t            x0,
   input  coord_t            y0,
   input  coord_t            x1,
   input  coord_t            y1,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   coord_t            x;
   coord_t            y;
   logic [ADDR_W-1:0] col_base;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x        <= '0;
         y        <= '0;
         col_base <= '0;
      end else if (start) begin
         x        <= x0;
         y        <= y0;
         col_base <= ADDR_W'(x0) * ADDR_W'(V_PIXELS);
      end else if (advance) begin
         if (y < y1) begin
            y <= y + 10'd1;
         end else if (x < x1) begin
            x        <= x + 10'd1;
            y        <= y0;
            col_base <= col_base + ADDR_W'(V_PIXELS);
         end
      end
   end

   assign addr = col_base + ADDR_W'(y);
   assign last = (x == x1) && (y == y1);

endmodule

// File: rtl/fb_rect_fill.sv
// ----------------------------------------------------------------------------
// fb_rect_fill
// Avalon-MM rectangle-fill engine. Software programs two corners and a
// colour, writes GO, and the block emits one framebuffer write per pixel
// over a valid/ready handshake.
// Optional build macro: FB_RECT_FILL_IRQ_EN builds the irq_pending flag and
// drives irq from it; otherwise irq is tied low and IRQ_CLR is ignored.
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   chipselect, write, read        Avalon slave strobes
//   address, writedata             register offset / write data
//   readdata                       registered status {irq_pending, err, busy}
//   fb_wr_valid, fb_wr_ready       framebuffer write handshake
//   fb_wr_addr, fb_wr_data         pixel address / colour
//   irq                            fill-complete interrupt
// ----------------------------------------------------------------------------
module fb_rect_fill
   import fb_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_PIXELS = V_PIXELS_DEF,
   parameter int ADDR_W   = FB_ADDR_W,
   parameter int DATA_W   = FB_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [3:0]        address,
   input  logic [7:0]        writedata,
   output logic [7:0]        readdata,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [DATA_W-1:0] fb_wr_data,
   output logic              irq
);

   localparam coord_t H_MAX = coord_t'(H_PIXELS - 1);
   localparam coord_t V_MAX = coord_t'(V_PIXELS - 1);

   fill_state_e state, state_next;

   coord_t            x0, y0, x1, y1;
   logic [DATA_W-1:0] color;
   coord_t            wx0, wy0, wx1, wy1;
   logic [DATA_W-1:0] wcolor;
   logic              busy;
   logic              err;
   logic              irq_pending;

   logic wr_en, go, coords_ok, walk_start, walk_last, fill_done;

   // Register writes are only honoured while idle, so an in-flight fill
   // always runs from its own working copies.
   assign wr_en     = chipselect && write && (state == IDLE);
   assign go        = wr_en && (address == REG_CTRL) && writedata[CTRL_GO];
   assign coords_ok = (x0 <= x1) && (x1 <= H_MAX) && (y0 <= y1) && (y1 <= V_MAX);
   assign fill_done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      state_next = state;
      walk_start = 1'b0;
      unique case (state)
         IDLE:  if (go && coords_ok) state_next = SETUP;
         SETUP: begin
            walk_start = 1'b1;
            state_next = RUN;
         end
         RUN:   if (fb_wr_valid && fb_wr_ready && walk_last) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         {x0, y0, x1, y1} <= '0;
         color            <= '0;
         {wx0, wy0, wx1, wy1} <= '0;
         wcolor           <= '0;
         busy             <= 1'b0;
         err              <= 1'b0;
      end else begin
         if (wr_en) begin
            case (address)
               REG_X0_HI: x0    <= coord_merge(x0, 1'b1, writedata);
               REG_X0_LO: x0    <= coord_merge(x0, 1'b0, writedata);
               REG_Y0_HI: y0    <= coord_merge(y0, 1'b1, writedata);
               REG_Y0_LO: y0    <= coord_merge(y0, 1'b0, writedata);
               REG_X1_HI: x1    <= coord_merge(x1, 1'b1, writedata);
               REG_X1_LO: x1    <= coord_merge(x1, 1'b0, writedata);
               REG_Y1_HI: y1    <= coord_merge(y1, 1'b1, writedata);
               REG_Y1_LO: y1    <= coord_merge(y1, 1'b0, writedata);
               REG_COLOR: color <= DATA_W'(writedata);
               default: ;
            endcase
         end
         if (go) begin
            err <= !coords_ok;
            if (coords_ok) begin
               {wx0, wy0, wx1, wy1} <= {x0, y0, x1, y1};
               wcolor               <= color;
               busy                 <= 1'b1;
            end
         end else if (fill_done) begin
            busy <= 1'b0;
         end
      end
   end

`ifdef FB_RECT_FILL_IRQ_EN
   // IRQ_CLR is evaluated before DONE so a completing fill wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_pending <= 1'b0;
      end else begin
         if (wr_en && (address == REG_CTRL) && writedata[CTRL_IRQ_CLR])
            irq_pending <= 1'b0;
         if (fill_done)
            irq_pending <= 1'b1;
      end
   end
   assign irq = irq_pending;
`else
   assign irq_pending = 1'b0;
   assign irq         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)               readdata <= '0;
      else if (chipselect && read) readdata <= {5'b0, irq_pending, err, busy};
   end

   fb_addr_walker #(
      .V_PIXELS (V_PIXELS),
      .ADDR_W   (ADDR_W)
   ) u_walker (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (walk_start),
      .advance (fb_wr_valid && fb_wr_ready),
      .x0      (wx0),
      .y0      (wy0),
      .x1      (wx1),
      .y1      (wy1),
      .addr    (fb_wr_addr),
      .last    (walk_last)
   );

   assign fb_wr_valid = (state == RUN);
   assign fb_wr_data  = wcolor;

endmodule

// File: tb/tb_fb_rect_fill.sv
// ----------------------------------------------------------------------------
// tb_fb_rect_fill
// Self-checking bench for fb_rect_fill. A reference model lists the expected
// column-major pixel sequence of each rectangle; a negedge monitor records
// every accepted framebuffer write and checks handshake stability.
// ----------------------------------------------------------------------------
module tb_fb_rect_fill;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        chipselect, write, read;
   logic [3:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        fb_wr_valid;
   logic        fb_wr_ready;
   logic [18:0] fb_wr_addr;
   logic [7:0]  fb_wr_data;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [26:0] got_q[$];
   logic [26:0] exp_q[$];
   bit          ready_rand = 1'b0;

   always #5 clk = ~clk;

   fb_rect_fill dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .chipselect  (chipselect),
      .write       (write),
      .read        (read),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .fb_wr_valid (fb_wr_valid),
      .fb_wr_ready (fb_wr_ready),
      .fb_wr_addr  (fb_wr_addr),
      .fb_wr_data  (fb_wr_data),
      .irq         (irq)
   );

   // Monitor: pick ready for the coming edge, then log the pixel that edge
   // will accept and verify a stalled request held still.
   initial begin : monitor
      bit          prev_stall = 1'b0;
      logic [18:0] prev_addr  = '0;
      logic [7:0]  prev_data  = '0;
      fb_wr_ready = 1'b1;
      forever begin
         @(negedge clk);
         fb_wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               checks++;
               if (fb_wr_valid !== 1'b1 || fb_wr_addr !== prev_addr || fb_wr_data !== prev_data) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                           fb_wr_valid, fb_wr_addr, fb_wr_data, prev_addr, prev_data);
               end
            end
            prev_stall = fb_wr_valid && !fb_wr_ready;
            prev_addr  = fb_wr_addr;
            prev_data  = fb_wr_data;
            if (fb_wr_valid && fb_wr_ready) got_q.push_back({fb_wr_addr, fb_wr_data});
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic void model_fill(input int x0, input int y0, input int x1,
                                      input int y1, input logic [7:0] c);
      exp_q.delete();
      for (int x = x0; x <= x1; x++)
         for (int y = y0; y <= y1; y++)
            exp_q.push_back({19'(x * 480 + y), c});
   endfunction

   // ---------------- bus helpers ----------------
   task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic read_status(output logic [7:0] s);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = 4'd0;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      s = readdata;
   endtask

   task automatic program_rect(input logic [9:0] x0, input logic [9:0] y0,
                               input logic [9:0] x1, input logic [9:0] y1,
                               input logic [7:0] c);
      reg_write(4'd0, {6'b0, x0[9:8]}); reg_write(4'd1, x0[7:0]);
      reg_write(4'd2, {6'b0, y0[9:8]}); reg_write(4'd3, y0[7:0]);
      reg_write(4'd4, {6'b0, x1[9:8]}); reg_write(4'd5, x1[7:0]);
      reg_write(4'd6, {6'b0, y1[9:8]}); reg_write(4'd7, y1[7:0]);
      reg_write(4'd8, c);
   endtask

   task automatic wait_idle(input string name);
      logic [7:0] s;
      for (int i = 0; i < 2000; i++) begin
         read_status(s);
         if (!s[0]) return;
      end
      checks++; errors++;
      $display("FAIL %s_timeout: busy still 1 after 2000 polls, required 0", name);
   endtask

   task automatic check_fill(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_pixel%0d: addr=%0d data=%h, required addr=%0d data=%h", name, i,
                     got_q[i][26:8], got_q[i][7:0], exp_q[i][26:8], exp_q[i][7:0]);
         end
      end
   endtask

   task automatic run_fill(input string name, input int x0, input int y0,
                           input int x1, input int y1, input logic [7:0] c);
      got_q.delete();
      model_fill(x0, y0, x1, y1, c);
      program_rect(10'(x0), 10'(y0), 10'(x1), 10'(y1), c);
      reg_write(4'd9, 8'h01);
      wait_idle(name);
      check_fill(name);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] s;
      reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fb_wr_valid, fb_wr_addr, fb_wr_data, irq, readdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b addr=%0d data=%h irq=%b readdata=%h, required all 0",
                  fb_wr_valid, fb_wr_addr, fb_wr_data, irq, readdata);
      end
      reset_n = 1'b1;
      read_status(s);
      checks++;
      if (s !== 8'h00) begin
         errors++;
         $display("FAIL reset_status: readdata=%h, required 00", s);
      end
   endtask

   task automatic test_single_pixel();
      logic [7:0] s;
      ready_rand = 1'b0;
      run_fill("single", 0, 0, 0, 0, 8'hFF);
      read_status(s);
      checks++;
      if (s[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: busy=%b, required 0", s[0]);
      end
   endtask

   task automatic test_go_latency();
      logic [18:0] lit [6];
      lit = '{19'd485, 19'd486, 19'd487, 19'd965, 19'd966, 19'd967};
      ready_rand = 1'b0;
      got_q.delete();
      model_fill(1, 5, 2, 7, 8'h3C);
      program_rect(10'd1, 10'd5, 10'd2, 10'd7, 8'h3C);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = 4'd9; writedata = 8'h01;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      checks++;
      if (fb_wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: valid=%b one cycle after GO, required 0", fb_wr_valid);
      end
      @(negedge clk);
      checks++;
      if (fb_wr_valid !== 1'b1 || fb_wr_addr !== 19'd485) begin
         errors++;
         $display("FAIL latency_first: valid=%b addr=%0d two cycles after GO, required valid=1 addr=485",
                  fb_wr_valid, fb_wr_addr);
      end
      wait_idle("latency");
      check_fill("latency");
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i][26:8] !== lit[i]) begin
            errors++;
            $display("FAIL latency_addr%0d: addr=%0d, required %0d", i, got_q[i][26:8], lit[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      ready_rand = 1'b1;
      run_fill("backpressure", 1, 5, 2, 7, 8'h3C);
      for (int n = 0; n < 6; n++) begin
         int x0 = $urandom_range(0, 630);
         int y0 = $urandom_range(0, 470);
         run_fill("random", x0, y0, x0 + $urandom_range(0, 5), y0 + $urandom_range(0, 5),
                  8'($urandom));
      end
      ready_rand = 1'b0;
   endtask

   task automatic test_invalid();
      logic [7:0] s;
      int         cfg [2][4];
      cfg = '{'{10, 0, 9, 0}, '{0, 0, 0, 480}};
      for (int k = 0; k < 2; k++) begin
         got_q.delete();
         program_rect(10'(cfg[k][0]), 10'(cfg[k][1]), 10'(cfg[k][2]), 10'(cfg[k][3]), 8'h55);
         reg_write(4'd9, 8'h01);
         read_status(s);
         checks++;
         if (s[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL invalid%0d_status: err/busy=%b, required 10", k, s[1:0]);
         end
         repeat (10) @(negedge clk);
         checks++;
         if (got_q.size() != 0) begin
            errors++;
            $display("FAIL invalid%0d_writes: got %0d writes, required 0", k, got_q.size());
         end
      end
      run_fill("after_invalid", 4, 4, 4, 5, 8'h11);
      read_status(s);
      checks++;
      if (s[1] !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b, required 0", s[1]);
      end
   endtask

   task automatic test_corner();
      ready_rand = 1'b0;
      run_fill("corner", 639, 479, 639, 479, 8'hA5);
   endtask

   task automatic test_go_while_busy();
      ready_rand = 1'b0;
      got_q.delete();
      model_fill(20, 30, 23, 33, 8'h7E);
      program_rect(10'd20, 10'd30, 10'd23, 10'd33, 8'h7E);
      reg_write(4'd9, 8'h01);
      reg_write(4'd1, 8'd0);
      reg_write(4'd8, 8'h00);
      reg_write(4'd9, 8'h01);
      wait_idle("busy_go");
      repeat (10) @(negedge clk);
      check_fill("busy_go");
   endtask

   task automatic test_reset_mid_fill();
      logic [7:0] s;
      ready_rand = 1'b0;
      program_rect(10'd3, 10'd3, 10'd6, 10'd6, 8'h99);
      reg_write(4'd9, 8'h01);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (fb_wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_valid: valid=%b, required 0", fb_wr_valid);
      end
      reset_n = 1'b1;
      read_status(s);
      checks++;
      if (s !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_status: readdata=%h irq=%b, required 00 and 0", s, irq);
      end
   endtask

   task automatic test_irq();
      logic [7:0] s;
      ready_rand = 1'b0;
      run_fill("irq_fill", 7, 8, 8, 9, 8'h42);
      read_status(s);
`ifdef FB_RECT_FILL_IRQ_EN
      checks++;
      if (irq !== 1'b1 || s[2] !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: irq=%b pending=%b, required 1 and 1", irq, s[2]);
      end
      reg_write(4'd9, 8'h02);
      read_status(s);
      checks++;
      if (irq !== 1'b0 || s[2] !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: irq=%b pending=%b, required 0 and 0", irq, s[2]);
      end
`else
      checks++;
      if (irq !== 1'b0 || s[2] !== 1'b0) begin
         errors++;
         $display("FAIL irq_disabled: irq=%b pending=%b, required 0 and 0", irq, s[2]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_go_latency();
      test_backpressure();
      test_invalid();
      test_corner();
      test_go_while_busy();
      test_reset_mid_fill();
      test_irq();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
